// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared direction encoding, reversal helper and scheduler states
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b00;
    localparam dir_t DIR_RIGHT = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b10;
    localparam dir_t DIR_LEFT  = 2'b11;

    // Opposite heading: flipping the top bit swaps up/down and right/left.
    function automatic dir_t dir_reverse(input dir_t d);
        return d ^ 2'b10;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_HALT  = 2'b11
    } sched_state_e;

endpackage

// File: rtl/dir_queue.sv
// rtl/dir_queue.sv - 2-entry direction request FIFO with tail/heading validation
module dir_queue
    import snake_pkg::*;
(
    input  logic       board_clk,
    input  logic       reset,
    input  logic       req_valid_i,
    input  logic [1:0] req_dir_i,
    input  logic       pop_i,
    input  logic       flush_i,
    input  logic [1:0] cur_dir_i,
    output logic [1:0] head_o,
    output logic [1:0] count_o
);

    logic [1:0] e0_q, e0_d;
    logic [1:0] e1_q, e1_d;
    logic [1:0] cnt_q, cnt_d;
    logic [1:0] ref_dir;
    logic       do_pop;
    logic       req_ok;
    logic       do_push;

    // Requests are judged against the newest queued heading, or the live heading when empty.
    always_comb begin
        ref_dir = cur_dir_i;
        if (cnt_q == 2'd2) begin
            ref_dir = e1_q;
        end else if (cnt_q == 2'd1) begin
            ref_dir = e0_q;
        end
        do_pop  = pop_i && (cnt_q != 2'd0);
        req_ok  = req_valid_i && (req_dir_i != ref_dir) && (req_dir_i != dir_reverse(ref_dir));
        do_push = req_ok && ((cnt_q != 2'd2) || do_pop);
    end

    // Pop shifts the tail into the head first, so a same-cycle push lands behind it.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        cnt_d = cnt_q;
        if (do_pop) begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
        end
        if (do_push) begin
            if (cnt_d == 2'd0) begin
                e0_d = req_dir_i;
            end else begin
                e1_d = req_dir_i;
            end
            cnt_d = cnt_d + 2'd1;
        end
        if (flush_i) begin
            cnt_d = 2'd0;
        end
    end

    // Queue storage and occupancy.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            e0_q  <= DIR_UP;
            e1_q  <= DIR_UP;
            cnt_q <= 2'd0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = e0_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/snake_move_scheduler.sv
// rtl/snake_move_scheduler.sv - run/pause/halt sequencing, game tick and heading queue
module snake_move_scheduler
    import snake_pkg::*;
#(
    parameter int TICK_CYCLES = 67108864,
    parameter int CNT_W       = 27
)(
    input  logic       board_clk,
    input  logic       reset,
    input  logic       up_scen,
    input  logic       right_scen,
    input  logic       down_scen,
    input  logic       left_scen,
    input  logic       ack_scen,
    input  logic       game_over,
    output logic       tick,
    output logic [1:0] dir,
    output logic       running,
    output logic       paused,
    output logic [1:0] q_count
);

    localparam logic [CNT_W-1:0] TC_LAST = CNT_W'(TICK_CYCLES - 1);

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [1:0]       dir_q, dir_d;
    logic             start_run;
    logic             halt_exit;
    logic             accept_req;
    logic             req_valid;
    logic [1:0]       req_dir;
    logic [1:0]       q_head;
    logic [1:0]       q_cnt;

    // State register.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; game_over outranks ack while running or paused.
    always_comb begin
        state_d    = state_q;
        start_run  = 1'b0;
        halt_exit  = 1'b0;
        accept_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                accept_req = 1'b1;
                if (ack_scen) begin
                    state_d   = ST_RUN;
                    start_run = 1'b1;
                end
            end
            ST_RUN: begin
                accept_req = 1'b1;
                if (game_over) begin
                    state_d = ST_HALT;
                end else if (ack_scen) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (game_over) begin
                    state_d = ST_HALT;
                end else if (ack_scen) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (ack_scen) begin
                    state_d   = ST_IDLE;
                    halt_exit = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counter advances only on edges that land in RUN, so a pause of P cycles costs exactly P.
    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (start_run || halt_exit) begin
            cnt_d = '0;
        end else if (state_d == ST_RUN) begin
            if (cnt_q == TC_LAST) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Fixed-priority pick of one press per cycle; the rest are dropped.
    always_comb begin
        req_valid = 1'b0;
        req_dir   = DIR_UP;
        if (accept_req) begin
            if (up_scen) begin
                req_valid = 1'b1;
                req_dir   = DIR_UP;
            end else if (right_scen) begin
                req_valid = 1'b1;
                req_dir   = DIR_RIGHT;
            end else if (down_scen) begin
                req_valid = 1'b1;
                req_dir   = DIR_DOWN;
            end else if (left_scen) begin
                req_valid = 1'b1;
                req_dir   = DIR_LEFT;
            end
        end
    end

    // Heading takes the queue head on the same edge that raises tick.
    always_comb begin
        dir_d = dir_q;
        if (halt_exit) begin
            dir_d = DIR_RIGHT;
        end else if (tick_d && (q_cnt != 2'd0)) begin
            dir_d = q_head;
        end
    end

    // Counter, tick and heading registers.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
            dir_q  <= DIR_RIGHT;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            dir_q  <= dir_d;
        end
    end

    dir_queue u_dir_queue (
        .board_clk   (board_clk),
        .reset       (reset),
        .req_valid_i (req_valid),
        .req_dir_i   (req_dir),
        .pop_i       (tick_d),
        .flush_i     (halt_exit),
        .cur_dir_i   (dir_q),
        .head_o      (q_head),
        .count_o     (q_cnt)
    );

    assign tick    = tick_q;
    assign dir     = dir_q;
    assign running = (state_q == ST_RUN);
    assign paused  = (state_q == ST_PAUSE);
    assign q_count = q_cnt;

endmodule
